// File: rtl/schmidl_cox_preamble_tx.sv
// Prepends a programmable periodic training preamble (P-sample pattern x N, then G zeros)
// to each payload packet; the payload itself is passed through combinationally.
module schmidl_cox_preamble_tx #(
    parameter int BASE        = 0,
    parameter int WIDTH       = 32,
    parameter int PERIOD_LOG2 = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             busy
);
    localparam int PW    = PERIOD_LOG2 + 1;
    localparam int DEPTH = 2 ** PERIOD_LOG2;
    localparam logic [PW-1:0]          PMAX   = PW'(DEPTH);
    localparam logic [PW-1:0]          P_ONE  = PW'(1);
    localparam logic [PERIOD_LOG2-1:0] PH_ONE = PERIOD_LOG2'(1);
    localparam logic [7:0] A_P = 8'(BASE);
    localparam logic [7:0] A_N = 8'(BASE + 1);
    localparam logic [7:0] A_G = 8'(BASE + 2);
    localparam logic [7:0] A_W = 8'(BASE + 3);
    localparam logic [7:0] A_R = 8'(BASE + 4);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_GAP, S_PAY} state_t;
    typedef enum logic [1:0] {G_PRE, G_GAP, G_DONE} gmode_t;

    state_t state, nstate;
    gmode_t gmode, cmode, nmode, init_mode;

    logic [PW-1:0]          p_reg, p_sh, cp;
    logic [15:0]            n_reg, n_sh, cn, g_reg, g_sh, cg;
    logic [15:0]            rep, crep, nrep, gcnt, cgc, ngc;
    logic [PERIOD_LOG2-1:0] wptr, ph, cph, nph, raddr;
    logic                   ph_end, iss_zero, iss_lp, iss_la;
    logic                   idle, start, adv, issue, accept;
    logic                   rd_vld, rd_zero, rd_lp, rd_la;
    logic                   o_vld, o_lp, o_la;
    logic [WIDTH-1:0]       o_data, ram_q;
    logic [WIDTH-1:0]       ram [DEPTH];

    // Settings registers; period saturates at the pattern RAM depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg <= PW'(16);
            n_reg <= 16'd10;
            g_reg <= '0;
            wptr  <= '0;
        end else begin
            if (set_stb) begin
                case (set_addr)
                    A_P: p_reg <= (set_data[15:0] > 16'(DEPTH)) ? PMAX : set_data[PW-1:0];
                    A_N: n_reg <= set_data[15:0];
                    A_G: g_reg <= set_data[15:0];
                    A_W: wptr  <= wptr + PH_ONE;
                    A_R: wptr  <= '0;
                    default: ;
                endcase
            end
            if (clear) wptr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (set_stb && set_addr == A_W) ram[wptr] <= set_data[WIDTH-1:0];
        if (issue) ram_q <= ram[raddr];
    end

    // Sample generator: in the IDLE start cycle it works from the live settings so the
    // first RAM read is issued immediately; afterwards it runs from the shadows.
    always_comb begin
        idle      = (state == S_IDLE);
        init_mode = (p_reg != '0 && n_reg != '0) ? G_PRE : (g_reg != '0) ? G_GAP : G_DONE;
        cp    = idle ? p_reg : p_sh;
        cn    = idle ? n_reg : n_sh;
        cg    = idle ? g_reg : g_sh;
        cmode = idle ? init_mode : gmode;
        cph   = idle ? '0 : ph;
        crep  = idle ? '0 : rep;
        cgc   = idle ? '0 : gcnt;
        nmode = cmode;
        nph   = cph;
        nrep  = crep;
        ngc   = cgc;
        ph_end   = 1'b0;
        iss_zero = 1'b0;
        iss_lp   = 1'b0;
        iss_la   = 1'b0;
        case (cmode)
            G_PRE: begin
                ph_end = ({1'b0, cph} == cp - P_ONE);
                iss_lp = ph_end && (crep == cn - 16'd1);
                iss_la = iss_lp && (cg == '0);
                nph    = ph_end ? '0 : cph + PH_ONE;
                nrep   = ph_end ? crep + 16'd1 : crep;
                if (iss_lp) nmode = (cg != '0) ? G_GAP : G_DONE;
            end
            G_GAP: begin
                iss_zero = 1'b1;
                iss_la   = (cgc == cg - 16'd1);
                ngc      = cgc + 16'd1;
                if (iss_la) nmode = G_DONE;
            end
            default: ;
        endcase
        raddr  = cph;
        start  = idle && i_tvalid && !clear;
        adv    = !o_vld || o_tready;
        issue  = !clear && (start || state == S_PRE || state == S_GAP) && (cmode != G_DONE) && adv;
        accept = o_vld && o_tready;
    end

    // Two-stage read pipeline (RAM register, output register) stalls as a unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gmode <= G_DONE;
            p_sh <= '0; n_sh <= '0; g_sh <= '0;
            ph <= '0; rep <= '0; gcnt <= '0;
            rd_vld <= 1'b0; rd_zero <= 1'b0; rd_lp <= 1'b0; rd_la <= 1'b0;
            o_vld <= 1'b0; o_data <= '0; o_lp <= 1'b0; o_la <= 1'b0;
        end else if (clear) begin
            gmode  <= G_DONE;
            rd_vld <= 1'b0;
            o_vld  <= 1'b0;
            o_data <= '0;
            o_lp   <= 1'b0;
            o_la   <= 1'b0;
        end else begin
            if (start) begin
                p_sh <= p_reg;
                n_sh <= n_reg;
                g_sh <= g_reg;
            end
            if (start || issue) begin
                gmode <= issue ? nmode : cmode;
                ph    <= issue ? nph : cph;
                rep   <= issue ? nrep : crep;
                gcnt  <= issue ? ngc : cgc;
            end
            if (adv) begin
                rd_vld  <= issue;
                rd_zero <= iss_zero;
                rd_lp   <= iss_lp;
                rd_la   <= iss_la;
                o_vld   <= rd_vld;
                o_lp    <= rd_lp;
                o_la    <= rd_la;
                if (rd_vld) o_data <= rd_zero ? '0 : ram_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate   = state;
        o_tvalid = o_vld;
        o_tdata  = o_data;
        o_tlast  = 1'b0;
        i_tready = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (i_tvalid) begin
                    case (init_mode)
                        G_PRE:   nstate = S_PRE;
                        G_GAP:   nstate = S_GAP;
                        default: nstate = S_PAY;
                    endcase
                end
            end
            S_PRE, S_GAP: begin
                if (accept) begin
                    if (o_la)      nstate = S_PAY;
                    else if (o_lp) nstate = S_GAP;
                end
            end
            S_PAY: begin
                o_tvalid = i_tvalid;
                o_tdata  = i_tdata;
                o_tlast  = i_tlast;
                i_tready = o_tready;
                if (i_tvalid && o_tready && i_tlast) nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
        if (clear) nstate = S_IDLE;
    end
endmodule

// File: tb/tb_schmidl_cox_preamble_tx.sv
// Scoreboard bench: expected beats are generated from the preamble rules when a packet
// is issued; a negedge monitor pops and compares every accepted output beat.
module tb_schmidl_cox_preamble_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1, clear = 1'b0, set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] i_tdata = '0, o_tdata;
    logic        i_tlast = 1'b0, i_tvalid = 1'b0, i_tready;
    logic        o_tlast, o_tvalid, o_tready = 1'b1, busy;

    int tests = 0, fails = 0, cyc = 0;
    int acc_cnt = 0, first_v = 0, last_c = 0, t0 = 0;
    bit sb_en = 1, chk_en = 1, pt_chk = 0, thr = 0, seen = 0, prev_stall = 0;
    logic [31:0] prev_d;
    logic [32:0] sb_q[$];
    logic [32:0] exp_b;
    int m_p = 16, m_n = 10, m_g = 0, m_wptr = 0;
    logic [31:0] m_ram [32];

    schmidl_cox_preamble_tx dut (
        .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .busy(busy)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [63:0] a, logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        o_tready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (chk_en && prev_stall)
                check("stall_hold", 64'({o_tvalid, o_tdata}), 64'({1'b1, prev_d}));
            if (o_tvalid && o_tready) begin
                acc_cnt++;
                if (!seen) begin first_v = cyc; seen = 1; end
                last_c = cyc;
                if (sb_en) begin
                    if (sb_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL beat: unexpected output %0h", o_tdata);
                    end else begin
                        exp_b = sb_q.pop_front();
                        check("beat", 64'({o_tlast, o_tdata}), 64'(exp_b));
                    end
                end
            end
            if (pt_chk && busy) begin
                check("pt_ready", 64'(i_tready), 64'(o_tready));
                if (i_tvalid)
                    check("pt_data", 64'({o_tvalid, o_tlast, o_tdata}), 64'({i_tvalid, i_tlast, i_tdata}));
            end
            prev_stall = chk_en && o_tvalid && !o_tready;
            prev_d = o_tdata;
        end
    end

    task automatic wr(int a, logic [31:0] d);
        set_stb = 1'b1; set_addr = 8'(a); set_data = d;
        @(posedge clk); #1;
        set_stb = 1'b0;
        case (a)
            0: m_p = (d[15:0] > 16'd32) ? 32 : int'(d[15:0]);
            1: m_n = int'(d[15:0]);
            2: m_g = int'(d[15:0]);
            3: begin m_ram[m_wptr] = d; m_wptr = (m_wptr + 1) % 32; end
            4: m_wptr = 0;
            default: ;
        endcase
    endtask

    task automatic push_preamble();
        for (int k = 0; k < m_p * m_n; k++) sb_q.push_back({1'b0, m_ram[k % m_p]});
        for (int k = 0; k < m_g; k++) sb_q.push_back(33'd0);
    endtask

    task automatic send_pkt(int len);
        logic [31:0] pl[$];
        bit hs;
        int w;
        for (int i = 0; i < len; i++) pl.push_back($urandom);
        push_preamble();
        for (int i = 0; i < len; i++) sb_q.push_back({i == len - 1, pl[i]});
        for (int i = 0; i < len; i++) begin
            if (thr) repeat ($urandom_range(0, 1)) begin i_tvalid = 1'b0; @(posedge clk); #1; end
            i_tvalid = 1'b1; i_tdata = pl[i]; i_tlast = (i == len - 1);
            if (i == 0) t0 = cyc;
            w = 0;
            do begin @(negedge clk); hs = i_tready; w++; end while (!hs && w < 20000);
            check("in_handshake", 64'(hs), 64'(1));
            @(posedge clk); #1;
            if (!hs) break;
        end
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((sb_q.size() != 0 || busy) && w < 5000) begin @(posedge clk); #1; w++; end
        check("drain", 64'(sb_q.size()), 64'(0));
        check("idle_after", 64'(busy), 64'(0));
    endtask

    task automatic abort_test(bit use_rst);
        int base, w;
        thr = 0; base = acc_cnt; w = 0;
        push_preamble();
        i_tvalid = 1'b1; i_tdata = $urandom; i_tlast = 1'b0;
        while (acc_cnt - base < 50 && w < 2000) begin @(posedge clk); #1; w++; end
        check("reach_beat50", 64'(acc_cnt - base), 64'(50));
        chk_en = 0; sb_en = 0;
        if (use_rst) begin
            reset = 1'b1; i_tvalid = 1'b0; #1;
        end else begin
            clear = 1'b1; i_tvalid = 1'b0; @(posedge clk); #1; clear = 1'b0;
        end
        check("abort_vld", 64'(o_tvalid), 64'(0));
        check("abort_last", 64'(o_tlast), 64'(0));
        check("abort_data", 64'(o_tdata), 64'(0));
        check("abort_rdy", 64'(i_tready), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        if (use_rst) begin
            @(posedge clk); #1; reset = 1'b0;
            m_p = 16; m_n = 10; m_g = 0;
        end
        m_wptr = 0;
        sb_q.delete();
        @(posedge clk); #1;
        sb_en = 1; chk_en = 1;
        if (use_rst) for (int i = 0; i < 16; i++) wr(3, 32'(200 + i));
        send_pkt(4);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk); #1;
        check("rst_vld", 64'(o_tvalid), 64'(0));
        check("rst_last", 64'(o_tlast), 64'(0));
        check("rst_data", 64'(o_tdata), 64'(0));
        check("rst_rdy", 64'(i_tready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) wr(3, 32'(i));

        // defaults: 160 preamble beats then 64 payload beats, bubble-free
        seen = 0; base = acc_cnt;
        send_pkt(64);
        drain();
        check("first_lat", 64'(first_v - t0), 64'(2));
        check("no_bubble", 64'(last_c - first_v), 64'(223));
        check("beat_count", 64'(acc_cnt - base), 64'(224));

        // P=8 N=2 G=5 under random throttling on both sides
        wr(0, 8); wr(1, 2); wr(2, 5);
        thr = 1;
        send_pkt(20); drain();
        send_pkt(1 + int'($urandom_range(0, 9))); drain();

        // N=0 G=0: pure pass-through
        wr(1, 0); wr(2, 0);
        pt_chk = 1;
        send_pkt(30); drain();
        pt_chk = 0;

        // period change mid-preamble affects only the next packet
        thr = 0;
        wr(0, 16); wr(1, 2);
        base = acc_cnt;
        fork
            send_pkt(8);
            begin
                for (int w = 0; w < 1000 && acc_cnt - base < 5; w++) begin @(posedge clk); #1; end
                wr(0, 4);
            end
        join
        drain();
        send_pkt(4); drain();

        // write pointer wrap over 33 words, then pointer reset
        wr(4, 0);
        for (int i = 0; i <= 32; i++) wr(3, 32'(100 + i));
        wr(0, 32); wr(1, 1);
        send_pkt(3); drain();
        wr(4, 0); wr(3, 7);
        send_pkt(3); drain();

        // abort mid-preamble by reset, then by clear
        wr(0, 16); wr(1, 10); wr(2, 0);
        abort_test(1);
        abort_test(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
